// File: rtl/decode_issue_stage_if.sv
// rtl/decode_issue_stage_if.sv - fetch/issue/writeback bus of the decode-issue stage
// Purpose: groups the instruction input handshake, the issued-instruction
//   output register, the writeback clear strobes, flush and the stall counter.
// Modports:
//   slave  - decode_issue_stage side (drives in_ready, issue fields, stall_cnt)
//   master - surrounding pipeline side (drives in_instr/in_valid, out_ready,
//            wb_*, flush)
interface decode_issue_stage_if #(
  parameter int OPW  = 5,
  parameter int REGW = 3,
  parameter int IMMW = 21,
  parameter int CNTW = 16
);
  logic [31:0]     in_instr;
  logic            in_valid;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [OPW-1:0]  exc;
  logic [REGW-1:0] rd;
  logic [REGW-1:0] rs1;
  logic [REGW-1:0] rs2;
  logic [IMMW-1:0] imm;
  logic            we_e;
  logic            we_v;
  logic            mem_rd;
  logic            mem_wr;
  logic            illegal;
  logic            wb_e_valid;
  logic [REGW-1:0] wb_e_addr;
  logic            wb_v_valid;
  logic [REGW-1:0] wb_v_addr;
  logic            flush;
  logic [CNTW-1:0] stall_cnt;

  modport slave (
    input  in_instr, in_valid, out_ready, wb_e_valid, wb_e_addr,
           wb_v_valid, wb_v_addr, flush,
    output in_ready, out_valid, exc, rd, rs1, rs2, imm, we_e, we_v,
           mem_rd, mem_wr, illegal, stall_cnt
  );

  modport master (
    output in_instr, in_valid, out_ready, wb_e_valid, wb_e_addr,
           wb_v_valid, wb_v_addr, flush,
    input  in_ready, out_valid, exc, rd, rs1, rs2, imm, we_e, we_v,
           mem_rd, mem_wr, illegal, stall_cnt
  );
endinterface

// File: rtl/decode_issue_stage.sv
// rtl/decode_issue_stage.sv - instruction decode with scalar/vector scoreboard and issue register
// Purpose: decodes 32-bit instructions ([31:27] op, [26:24] rd, [23:21] rs1,
//   [20:18] rs2, [20:0] imm), stalls on RAW/WAW hazards against the pending
//   scalar/vector destination masks, and issues at most one instruction per
//   cycle through a registered valid/ready output.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - decode_issue_stage_if.slave: in_instr/in_valid/in_ready input
//           handshake, out_valid/out_ready plus exc/rd/rs1/rs2/imm/we_e/we_v/
//           mem_rd/mem_wr/illegal issue fields, wb_e_*/wb_v_* pending-bit
//           clears, flush, stall_cnt
module decode_issue_stage #(
  parameter int OPW  = 5,
  parameter int REGW = 3,
  parameter int IMMW = 21,
  parameter int CNTW = 16
) (
  input logic                clk,
  input logic                rst_n,
  decode_issue_stage_if.slave bus
);
  localparam int NR = 1 << REGW;
  localparam int PW = OPW + 3 * REGW + IMMW + 5;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  logic [OPW-1:0]  op;
  logic [REGW-1:0] rd_f, rs1_f, rs2_f;
  logic [IMMW-1:0] imm_f;
  logic [NR-1:0]   rd_oh, rs1_oh, rs2_oh;
  logic [NR-1:0]   src_e, src_v, dst_e, dst_v;
  logic            legal, m_rd, m_wr;

  logic [NR-1:0]   pending_e_q, pending_e_d, pending_v_q, pending_v_d;
  logic [PW-1:0]   issue_q, issue_d;
  logic            out_valid_q, out_valid_d;
  logic [0:0]      state_q, state_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic            hazard, stall_cond, accept, load;

  assign op    = bus.in_instr[31 -: OPW];
  assign rd_f  = bus.in_instr[26 -: REGW];
  assign rs1_f = bus.in_instr[23 -: REGW];
  assign rs2_f = bus.in_instr[20 -: REGW];
  assign imm_f = bus.in_instr[IMMW-1:0];

  assign rd_oh  = {{(NR-1){1'b0}}, 1'b1} << rd_f;
  assign rs1_oh = {{(NR-1){1'b0}}, 1'b1} << rs1_f;
  assign rs2_oh = {{(NR-1){1'b0}}, 1'b1} << rs2_f;

  always_comb begin
    legal = 1'b1;
    src_e = '0;
    src_v = '0;
    dst_e = '0;
    dst_v = '0;
    m_rd  = 1'b0;
    m_wr  = 1'b0;
    case (op)
      5'b00000: ;
      5'b00001: dst_e = rd_oh;
      5'b00101, 5'b00111: begin
        dst_e = rd_oh;
        src_e = rs1_oh;
      end
      5'b01110: begin
        dst_e = rd_oh;
        src_e = rs1_oh | rs2_oh;
      end
      5'b01010: begin
        dst_v = rd_oh;
        src_v = rs1_oh | rs2_oh;
      end
      5'b00010: begin
        dst_v = rd_oh;
        src_e = rs1_oh;
      end
      5'b01000, 5'b01100: begin
        dst_v = rd_oh;
        src_v = rs1_oh;
        src_e = rs2_oh;
      end
      5'b11100: begin
        src_e = rs1_oh;
        if (bus.in_instr[20]) begin
          // Store reads the vector register named by rd; it has no destination.
          src_v = rd_oh;
          m_wr  = 1'b1;
        end else begin
          dst_v = rd_oh;
          m_rd  = 1'b1;
        end
      end
      default: legal = 1'b0;
    endcase
  end

  // Destination bits are included so a second writer waits for the first (WAW).
  assign hazard     = |((src_e | dst_e) & pending_e_q) | |((src_v | dst_v) & pending_v_q);
  assign stall_cond = bus.in_valid & hazard;
  assign bus.in_ready = rst_n & (!out_valid_q | bus.out_ready) & !stall_cond;
  assign accept     = bus.in_valid & bus.in_ready;
  // A flushed accept is dropped entirely, so it must not reserve a register.
  assign load       = accept & !bus.flush;

  always_comb begin
    issue_d     = issue_q;
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      issue_d     = {(legal ? op : {OPW{1'b0}}), rd_f, rs1_f, rs2_f, imm_f,
                     |dst_e, |dst_v, m_rd, m_wr, !legal};
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear first, then set, so a same-edge set of the same bit wins.
  always_comb begin
    pending_e_d = pending_e_q;
    pending_v_d = pending_v_q;
    if (bus.wb_e_valid) pending_e_d[bus.wb_e_addr] = 1'b0;
    if (bus.wb_v_valid) pending_v_d[bus.wb_v_addr] = 1'b0;
    if (load) begin
      pending_e_d = pending_e_d | dst_e;
      pending_v_d = pending_v_d | dst_v;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (stall_cond) state_d = ST_STALL;
      ST_STALL: if (!stall_cond) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    stall_cnt_d = stall_cnt_q;
    if (state_d == ST_STALL && stall_cnt_q != {CNTW{1'b1}})
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_q     <= '0;
      out_valid_q <= 1'b0;
      pending_e_q <= '0;
      pending_v_q <= '0;
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      issue_q     <= issue_d;
      out_valid_q <= out_valid_d;
      pending_e_q <= pending_e_d;
      pending_v_q <= pending_v_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign {bus.exc, bus.rd, bus.rs1, bus.rs2, bus.imm,
          bus.we_e, bus.we_v, bus.mem_rd, bus.mem_wr, bus.illegal} = issue_q;
  assign bus.out_valid = out_valid_q;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_decode_issue_stage.sv
// tb/tb_decode_issue_stage.sv - directed self-checking bench for decode_issue_stage
module tb_decode_issue_stage;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  decode_issue_stage_if bus ();

  decode_issue_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [20:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.in_instr   = '0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.wb_e_valid = 1'b0;
    bus.wb_e_addr  = '0;
    bus.wb_v_valid = 1'b0;
    bus.wb_v_addr  = '0;
    bus.flush      = 1'b0;
    step();
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_exc", bus.exc, 0);
    check("rst_stall_cnt", bus.stall_cnt, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_pend_e", dut.pending_e_q, 0);
    rst_n = 1'b1;
    #1;

    // 1) MOV.E rd=2 imm=10
    bus.in_instr = mk(5'b00001, 3'd2, 3'd0, 21'd10);
    bus.in_valid = 1'b1;
    #1;
    check("t1_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("t1_out_valid", bus.out_valid, 1);
    check("t1_exc", bus.exc, 5'b00001);
    check("t1_we_e", bus.we_e, 1);
    check("t1_rd", bus.rd, 2);
    check("t1_imm", bus.imm, 10);
    check("t1_pend_e", dut.pending_e_q, 8'h04);

    // 2) ADD.E rd=3 rs1=2 stalls until writeback of e2
    bus.in_instr = mk(5'b00101, 3'd3, 3'd2, 21'd0);
    bus.in_valid = 1'b1;
    #1;
    check("t2_in_ready_haz", bus.in_ready, 0);
    step();
    check("t2_cnt1", bus.stall_cnt, 1);
    check("t2_drain", bus.out_valid, 0);
    step();
    check("t2_cnt2", bus.stall_cnt, 2);
    bus.wb_e_valid = 1'b1;
    bus.wb_e_addr  = 3'd2;
    #1;
    check("t2_no_bypass", bus.in_ready, 0);
    step();
    bus.wb_e_valid = 1'b0;
    #1;
    check("t2_cnt3", bus.stall_cnt, 3);
    check("t2_pend_clr", dut.pending_e_q, 8'h00);
    check("t2_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("t2_out_valid", bus.out_valid, 1);
    check("t2_exc", bus.exc, 5'b00101);
    check("t2_rd", bus.rd, 3);
    check("t2_rs1", bus.rs1, 2);
    check("t2_pend_e", dut.pending_e_q, 8'h08);
    check("t2_cnt_hold", bus.stall_cnt, 3);

    // 3) ADD.V rd=1 rs1=4 rs2=5, then held 3 cycles under back-pressure
    bus.in_instr = mk(5'b01010, 3'd1, 3'd4, 21'(5 << 18));
    bus.in_valid = 1'b1;
    #1;
    check("t3_in_ready", bus.in_ready, 1);
    step();
    bus.out_ready = 1'b0;
    bus.in_instr  = mk(5'b00001, 3'd7, 3'd0, 21'd99);
    #1;
    check("t3_bp_in_ready", bus.in_ready, 0);
    check("t3_pend_v", dut.pending_v_q, 8'h02);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_hold_valid", bus.out_valid, 1);
      check("t3_hold_exc", bus.exc, 5'b01010);
      check("t3_hold_rd", bus.rd, 1);
      check("t3_hold_rs1", bus.rs1, 4);
      check("t3_hold_rs2", bus.rs2, 5);
      check("t3_hold_we_v", bus.we_v, 1);
      check("t3_hold_we_e", bus.we_e, 0);
      check("t3_hold_in_ready", bus.in_ready, 0);
      check("t3_hold_cnt", bus.stall_cnt, 3);
    end
    bus.out_ready = 1'b1;
    #1;
    check("t3_release", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("t3_next_exc", bus.exc, 5'b00001);
    check("t3_next_rd", bus.rd, 7);
    check("t3_next_imm", bus.imm, 99);
    check("t3_pend_e", dut.pending_e_q, 8'h88);

    // 4) ST rd=1 waits for v1, issues with mem_wr and no new pending bit
    bus.in_instr = mk(5'b11100, 3'd1, 3'd0, 21'h100000);
    bus.in_valid = 1'b1;
    #1;
    check("t4_in_ready_haz", bus.in_ready, 0);
    step();
    check("t4_cnt4", bus.stall_cnt, 4);
    bus.wb_v_valid = 1'b1;
    bus.wb_v_addr  = 3'd1;
    step();
    bus.wb_v_valid = 1'b0;
    #1;
    check("t4_cnt5", bus.stall_cnt, 5);
    check("t4_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("t4_exc", bus.exc, 5'b11100);
    check("t4_mem_wr", bus.mem_wr, 1);
    check("t4_mem_rd", bus.mem_rd, 0);
    check("t4_we_v", bus.we_v, 0);
    check("t4_we_e", bus.we_e, 0);
    check("t4_pend_v", dut.pending_v_q, 8'h00);
    check("t4_pend_e", dut.pending_e_q, 8'h88);

    // 5) illegal op 10101 with pending-looking fields, then flushed copy
    bus.in_instr = mk(5'b10101, 3'd3, 3'd7, 21'd0);
    bus.in_valid = 1'b1;
    #1;
    check("t5_in_ready", bus.in_ready, 1);
    step();
    check("t5_out_valid", bus.out_valid, 1);
    check("t5_exc", bus.exc, 0);
    check("t5_illegal", bus.illegal, 1);
    check("t5_we_e", bus.we_e, 0);
    check("t5_pend_e", dut.pending_e_q, 8'h88);
    check("t5_cnt", bus.stall_cnt, 5);
    bus.flush = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_flush_valid", bus.out_valid, 0);
    check("t5_flush_pend_e", dut.pending_e_q, 8'h88);

    // 6) same-edge wb_v clear of v6 and issue of MUL.V rd=6
    bus.in_instr   = mk(5'b01000, 3'd6, 3'd2, 21'd0);
    bus.in_valid   = 1'b1;
    bus.wb_v_valid = 1'b1;
    bus.wb_v_addr  = 3'd6;
    #1;
    check("t6_in_ready", bus.in_ready, 1);
    step();
    bus.wb_v_valid = 1'b0;
    check("t6_pend_v", dut.pending_v_q, 8'h40);
    check("t6_exc", bus.exc, 5'b01000);
    check("t6_we_v", bus.we_v, 1);
    bus.in_instr = mk(5'b01010, 3'd0, 3'd6, 21'd0);
    #1;
    check("t6_dep_stall", bus.in_ready, 0);
    step();
    check("t6_cnt6", bus.stall_cnt, 6);

    // Reset while stalled drops everything
    rst_n = 1'b0;
    #1;
    check("rs_out_valid", bus.out_valid, 0);
    check("rs_pend_v", dut.pending_v_q, 0);
    check("rs_pend_e", dut.pending_e_q, 0);
    check("rs_cnt", bus.stall_cnt, 0);
    check("rs_in_ready", bus.in_ready, 0);
    step();
    rst_n = 1'b1;
    #1;
    check("rs_after_ready", bus.in_ready, 1);
    step();
    check("rs_reissue", bus.out_valid, 1);
    check("rs_reissue_exc", bus.exc, 5'b01010);
    check("rs_cnt_after", bus.stall_cnt, 0);
    bus.in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
